// File: rtl/dmem_bridge.sv
// dmem_bridge: memory-stage to data-memory bus bridge.
//
// Turns each M-stage load or store into exactly one req/ack bus transaction
// and holds the pipeline with stallM until the transaction finishes.
// Misaligned accesses never reach the bus; they complete at once with an
// error pulse. A transaction that sees no ack for TIMEOUT BUSY cycles is
// aborted with an error pulse.
//
// Handshake: mem_req rises on entry to BUSY and stays high, with mem_we,
// mem_addr and mem_wdata frozen, until the cycle in which mem_ack is sampled
// high (or the timeout expires). mem_ack is ignored whenever mem_req is low.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   memreadM      M-stage load
//   memwriteM     M-stage store (wins over memreadM)
//   aluoutM       byte address
//   writedataM    store data
//   readdataM     registered load data (ERRDATA on error)
//   stallM        combinational pipeline hold
//   memerrM       one-cycle error pulse (misaligned or timeout)
//   mem_req/mem_we/mem_addr/mem_wdata   registered bus request
//   mem_ack/mem_rdata                   bus response
//   o_dbg_state   current FSM state (0 IDLE, 1 BUSY, 2 DONE)
`timescale 1ns/1ps
module dmem_bridge #(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] ERRDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        memerrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  o_dbg_state
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_count;
  logic [31:0]    r_readdata;
  logic           r_memerr;
  logic           r_req;
  logic           r_we;
  logic [31:0]    r_addr;
  logic [31:0]    r_wdata;

  logic w_acc;
  logic w_misaligned;
  logic w_timeout;

  assign w_acc        = memreadM | memwriteM;
  assign w_misaligned = (aluoutM[1:0] != 2'b00);
  assign w_timeout    = (r_count == CW'(TIMEOUT - 1));

  // Stall is combinational so the pipeline freezes in the same cycle the
  // access is first seen in IDLE; DONE always releases it for one cycle.
  always_comb begin
    stallM = 1'b0;
    case (r_state)
      S_IDLE:  stallM = w_acc;
      S_BUSY:  stallM = 1'b1;
      default: stallM = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_readdata <= 32'h0;
      r_memerr   <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
    end else begin
      // Error flag is a pulse: only the transition into DONE may raise it.
      r_memerr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            if (w_misaligned) begin
              r_state  <= S_DONE;
              r_memerr <= 1'b1;
              if (!memwriteM) r_readdata <= ERRDATA;
            end else begin
              r_state <= S_BUSY;
              r_req   <= 1'b1;
              r_we    <= memwriteM;
              r_addr  <= {aluoutM[31:2], 2'b00};
              r_wdata <= writedataM;
              r_count <= '0;
            end
          end
        end
        S_BUSY: begin
          // An ack in the last allowed cycle still completes normally.
          if (mem_ack) begin
            if (!r_we) r_readdata <= mem_rdata;
            r_req   <= 1'b0;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            if (!r_we) r_readdata <= ERRDATA;
            r_memerr <= 1'b1;
            r_req    <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign readdataM   = r_readdata;
  assign memerrM     = r_memerr;
  assign mem_req     = r_req;
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: directed table, reset-during-BUSY sequence and a
// randomized phase checked against a transaction-level model.
`timescale 1ns/1ps
module tb_dmem_bridge;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] ERRDATA = 32'hDEADBEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        memreadM = 1'b0, memwriteM = 1'b0;
  logic [31:0] aluoutM = 32'h0, writedataM = 32'h0;
  logic [31:0] readdataM;
  logic        stallM, memerrM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [1:0]  dbg_state;

  dmem_bridge #(.TIMEOUT(TIMEOUT), .ERRDATA(ERRDATA)) dut (
    .clk(clk), .rst(rst),
    .memreadM(memreadM), .memwriteM(memwriteM),
    .aluoutM(aluoutM), .writedataM(writedataM),
    .readdataM(readdataM), .stallM(stallM), .memerrM(memerrM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .o_dbg_state(dbg_state)
  );

  // ---------------- bus responder ----------------
  // resp_nb = number of BUSY cycles until ack, counting the ack cycle
  // (1 = ack in the first BUSY cycle, 0 = never ack).
  int          resp_nb = 0;
  logic [31:0] resp_rdata = 32'h0;
  logic        force_ack = 1'b0;
  int          req_cyc = 0;

  always @(negedge clk) begin
    if (mem_req) begin
      mem_ack   = (resp_nb != 0) && (req_cyc == resp_nb - 1);
      mem_rdata = mem_ack ? resp_rdata : $urandom;
      req_cyc++;
    end else begin
      mem_ack   = force_ack;
      mem_rdata = force_ack ? 32'h5555AAAA : $urandom;
      req_cyc   = 0;
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: what one access must look like from outside.
  function automatic void model(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] rdata, input int nb,
                                output int st, output int rq, output logic er,
                                inout logic [31:0] rdv);
    logic is_load;
    logic to;
    is_load = rd && !wr;
    if (addr[1:0] != 2'b00) begin
      st = 1; rq = 0; er = 1'b1;
      if (is_load) rdv = ERRDATA;
    end else begin
      to = (nb == 0) || (nb > TIMEOUT);
      rq = to ? TIMEOUT : nb;
      st = rq + 1;
      er = to;
      if (is_load) rdv = to ? ERRDATA : rdata;
    end
  endfunction

  // ---------------- driver ----------------
  // Entered at posedge+1 with the DUT in IDLE; returns at posedge+1 of the
  // IDLE cycle following DONE.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int nb,
                           input int e_stall, input int e_req, input logic e_err,
                           input logic [31:0] e_rd);
    int   stall_n = 0, req_n = 0, err_early = 0, bad_bus = 0;
    bit   done = 0;
    logic [31:0] exp_rd;
    exp_q.push_back(e_rd);
    memreadM = rd; memwriteM = wr; aluoutM = addr; writedataM = wdata;
    resp_nb = nb; resp_rdata = rdata;
    #1;
    for (int c = 0; c < TIMEOUT + 8 && !done; c++) begin
      if (stallM) begin
        stall_n++;
        if (memerrM) err_early++;
        if (mem_req) begin
          req_n++;
          if (mem_addr !== {addr[31:2], 2'b00} || mem_we !== wr || mem_wdata !== wdata)
            bad_bus++;
        end
        @(posedge clk); #1;
      end else begin
        done = 1;
        exp_rd = exp_q.pop_front();
        check({tag, ".done_memerr"}, {31'h0, memerrM}, {31'h0, e_err});
        check({tag, ".done_readdata"}, readdataM, exp_rd);
        check({tag, ".done_req"}, {31'h0, mem_req}, 32'h0);
      end
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s.no_done: stallM never released", tag);
      void'(exp_q.pop_front());
    end
    check({tag, ".stall_cycles"}, stall_n, e_stall);
    check({tag, ".req_cycles"}, req_n, e_req);
    check({tag, ".early_memerr"}, err_early, 0);
    check({tag, ".bus_stable"}, bad_bus, 0);
    memreadM = 1'b0; memwriteM = 1'b0;
    @(posedge clk); #1;
    check({tag, ".idle_memerr"}, {31'h0, memerrM}, 32'h0);
    check({tag, ".idle_req"}, {31'h0, mem_req}, 32'h0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string       tag;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    int          nb;
    int          e_stall, e_req;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] model_rd;
    int st, rq;
    logic er;
    logic rd, wr;
    logic [31:0] a;
    int nb;

    vecs[0] = '{"ld_ok",      1, 0, 32'h10, 32'h0,        32'h12345678, 1,  2,  1,  0, 32'h12345678};
    vecs[1] = '{"st_delay5",  0, 1, 32'h24, 32'hCAFEF00D, 32'h0,        5,  6,  5,  0, 32'h12345678};
    vecs[2] = '{"ld_misal",   1, 0, 32'h13, 32'h0,        32'h0,        1,  1,  0,  1, 32'hDEADBEEF};
    vecs[3] = '{"ld_lastack", 1, 0, 32'h40, 32'h0,        32'hA5A5A5A5, 16, 17, 16, 0, 32'hA5A5A5A5};
    vecs[4] = '{"ld_timeout", 1, 0, 32'h44, 32'h0,        32'h0BADF00D, 0,  17, 16, 1, 32'hDEADBEEF};
    vecs[5] = '{"b2b_ld",     1, 0, 32'h20, 32'h0,        32'h11112222, 1,  2,  1,  0, 32'h11112222};
    vecs[6] = '{"b2b_st",     0, 1, 32'h24, 32'h33334444, 32'h0,        1,  2,  1,  0, 32'h11112222};
    vecs[7] = '{"st_misal",   0, 1, 32'h26, 32'h0,        32'h0,        1,  1,  0,  1, 32'h11112222};
    vecs[8] = '{"rd_wr_both", 1, 1, 32'h30, 32'h77778888, 32'h99990000, 2,  3,  2,  0, 32'h11112222};
    vecs[9] = '{"ld_lateack", 1, 0, 32'h50, 32'h0,        32'h13579BDF, 17, 17, 16, 1, 32'hDEADBEEF};

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst.readdata", readdataM, 32'h0);
    check("rst.memerr", {31'h0, memerrM}, 32'h0);
    check("rst.req", {31'h0, mem_req}, 32'h0);
    check("rst.we", {31'h0, mem_we}, 32'h0);
    check("rst.addr", mem_addr, 32'h0);
    check("rst.wdata", mem_wdata, 32'h0);
    check("rst.state", {30'h0, dbg_state}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle.stall", {31'h0, stallM}, 32'h0);

    for (int i = 0; i < 10; i++)
      do_access(vecs[i].tag, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].rdata, vecs[i].nb, vecs[i].e_stall, vecs[i].e_req,
                vecs[i].e_err, vecs[i].e_rd);

    // reset in the third BUSY cycle, then a stray ack two cycles later
    memreadM = 1'b1; aluoutM = 32'h60; resp_nb = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid.req_busy", {31'h0, mem_req}, 32'h1);
    rst = 1'b1; memreadM = 1'b0;
    @(posedge clk); #1;
    check("mid.req", {31'h0, mem_req}, 32'h0);
    check("mid.readdata", readdataM, 32'h0);
    check("mid.memerr", {31'h0, memerrM}, 32'h0);
    check("mid.addr", mem_addr, 32'h0);
    check("mid.we", {31'h0, mem_we}, 32'h0);
    check("mid.wdata", mem_wdata, 32'h0);
    check("mid.state", {30'h0, dbg_state}, 32'h0);
    check("mid.stall", {31'h0, stallM}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    force_ack = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("late.readdata", readdataM, 32'h0);
      check("late.memerr", {31'h0, memerrM}, 32'h0);
      check("late.req", {31'h0, mem_req}, 32'h0);
      check("late.state", {30'h0, dbg_state}, 32'h0);
      @(posedge clk); #1;
    end

    // randomized phase
    model_rd = 32'h0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: begin rd = 1'b1; wr = 1'b0; end
        1: begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      a = $urandom;
      a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      nb = $urandom_range(0, TIMEOUT + 2);
      resp_rdata = $urandom;
      model(rd, wr, a, resp_rdata, nb, st, rq, er, model_rd);
      do_access("rand", rd, wr, a, $urandom, resp_rdata, nb, st, rq, er, model_rd);
      if ($urandom_range(0, 3) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          check("rand.idle_stall", {31'h0, stallM}, 32'h0);
          @(posedge clk); #1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
